// File: rtl/pipo_reg_if.sv
// Data bundle for pipo_reg: parallel word in (d) and registered word out (q).
interface pipo_reg_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;

    modport master (output d, input q);
    modport slave (input d, output q);
endinterface

// File: rtl/pipo_reg.sv
// Parallel-in/parallel-out register with STAGES flop stages and synchronous clear to RESET_VALUE.
// Define PIPO_REG_ASSERT_EN to compile in simulation-only behavioural checks (no hardware change).
module pipo_reg #(
    parameter int          WIDTH       = 4,
    parameter int          STAGES      = 1,
    parameter logic [63:0] RESET_VALUE = 64'd0
) (
    input logic      clk,
    input logic      clear,
    pipo_reg_if.slave bus
);

    localparam logic [WIDTH-1:0] ResetVal = WIDTH'(RESET_VALUE);

    if (WIDTH < 1 || STAGES < 1) begin : gen_bad_param
        $error("pipo_reg: WIDTH (%0d) and STAGES (%0d) must both be >= 1", WIDTH, STAGES);
    end

    logic [WIDTH-1:0] s_q [STAGES];

    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < STAGES; i++) begin
                s_q[i] <= ResetVal;
            end
        end else begin
            s_q[0] <= bus.d;
            for (int i = 1; i < STAGES; i++) begin
                s_q[i] <= s_q[i-1];
            end
        end
    end

    assign bus.q = s_q[STAGES-1];

`ifdef PIPO_REG_ASSERT_EN
    // Checks read q before this edge's update, i.e. the value produced by earlier edges.
    logic             clear_p_q;
    int               run_q;
    logic [WIDTH-1:0] hist_q [STAGES];

    always @(posedge clk) begin
        if ($isunknown(clear)) begin
            $error("%0t pipo_reg: clear is X/Z at rising edge", $time);
        end
        if (clear_p_q === 1'b1 && bus.q !== ResetVal) begin
            $error("%0t pipo_reg: after clear expected q=%h actual q=%h", $time, ResetVal, bus.q);
        end else if (run_q >= STAGES && bus.q !== hist_q[STAGES-1]) begin
            $error("%0t pipo_reg: pipeline expected q=%h actual q=%h", $time, hist_q[STAGES-1],
                   bus.q);
        end
        clear_p_q <= clear;
        run_q     <= (clear !== 1'b0) ? 0 : ((run_q < STAGES) ? run_q + 1 : run_q);
        hist_q[0] <= bus.d;
        for (int i = 1; i < STAGES; i++) begin
            hist_q[i] <= hist_q[i-1];
        end
    end
`else
`endif

endmodule

// File: tb/tb_pipo_reg.sv
// Directed self-checking bench for pipo_reg: default build plus a STAGES=3, RESET_VALUE=A instance.
module tb_pipo_reg;

    logic clk   = 1'b0;
    logic clear = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #1 clk = ~clk;

    pipo_reg_if #(.WIDTH(4)) bus1 ();
    pipo_reg_if #(.WIDTH(4)) bus3 ();

    pipo_reg #(.WIDTH(4), .STAGES(1), .RESET_VALUE(64'd0)) dut1 (
        .clk   (clk),
        .clear (clear),
        .bus   (bus1.slave)
    );

    pipo_reg #(.WIDTH(4), .STAGES(3), .RESET_VALUE(64'hA)) dut3 (
        .clk   (clk),
        .clear (clear),
        .bus   (bus3.slave)
    );

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    logic [3:0] vec2 [6] = '{4'b0011, 4'b0111, 4'b1011, 4'b1001, 4'b1111, 4'b0001};
    logic [3:0] vec3 [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    initial begin
        // Step 1: clear with d unknown.
        bus1.d = 4'bxxxx;
        bus3.d = 4'bxxxx;
        @(negedge clk);
        check("reset_q1_e1", bus1.q, 4'b0000);
        check("reset_q3_e1", bus3.q, 4'hA);
        @(negedge clk);
        check("reset_q1_e2", bus1.q, 4'b0000);
        check("reset_q3_e2", bus3.q, 4'hA);

        // Step 2: held values, q follows one edge later.
        clear  = 1'b0;
        bus3.d = 4'h0;
        for (int i = 0; i < 6; i++) begin
            bus1.d = vec2[i];
            @(negedge clk);
            check("held_first", bus1.q, vec2[i]);
            @(negedge clk);
            check("held_second", bus1.q, vec2[i]);
        end

        // Step 3: new word every edge.
        for (int i = 0; i < 4; i++) begin
            bus1.d = vec3[i];
            @(negedge clk);
            check("b2b", bus1.q, vec3[i]);
        end

        // Step 4: one-edge clear pulse while d=1111.
        bus1.d = 4'b1111;
        @(negedge clk);
        check("pre_pulse", bus1.q, 4'b1111);
        clear = 1'b1;
        @(negedge clk);
        check("pulse_clear", bus1.q, 4'b0000);
        clear = 1'b0;
        @(negedge clk);
        check("pulse_release", bus1.q, 4'b1111);

        // Step 5: three-stage latency after clear.
        clear  = 1'b1;
        bus3.d = 4'h5;
        @(negedge clk);
        check("s3_clear", bus3.q, 4'hA);
        clear = 1'b0;
        @(negedge clk);
        check("s3_edge1", bus3.q, 4'hA);
        @(negedge clk);
        check("s3_edge2", bus3.q, 4'hA);
        @(negedge clk);
        check("s3_edge3", bus3.q, 4'h5);

        // Mid-stream clear discards in-flight words.
        bus3.d = 4'h6;
        @(negedge clk);
        check("s3_inflight", bus3.q, 4'h5);
        clear = 1'b1;
        @(negedge clk);
        check("s3_midclear", bus3.q, 4'hA);
        check("s1_midclear", bus1.q, 4'h0);
        clear  = 1'b0;
        bus3.d = 4'h3;
        @(negedge clk);
        check("s3_flush1", bus3.q, 4'hA);
        @(negedge clk);
        check("s3_flush2", bus3.q, 4'hA);
        @(negedge clk);
        check("s3_flush3", bus3.q, 4'h3);
        check("s1_after", bus1.q, 4'b1111);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
